// File: rtl/fwd_hazard_unit_p.sv
// Forwarding and load-use hazard unit. A DEPTH-deep scoreboard of in-flight
// producers drives the EX operand selects, load-use bubbles and a stall counter.
module fwd_hazard_unit_p #(
   parameter int REG_AW = 5,
   parameter int DEPTH  = 3,
   parameter int CNT_W  = 16,
   parameter int SEL_W  = $clog2(DEPTH + 2)
) (
   input  logic              clk,
   input  logic              reset2,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_is_load,
   input  logic              flush,
   input  logic              clear_count,
   output logic [SEL_W-1:0]  rs1_src,
   output logic [SEL_W-1:0]  rs2_src,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [SEL_W-1:0] SEL_LOAD = SEL_W'(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // Entry 1 is the instruction in EX; higher indices are older.
   logic [DEPTH:1]    sb_v;
   logic [DEPTH:1]    sb_ld;
   logic [REG_AW-1:0] sb_rd [1:DEPTH];

   logic m1_rs1;
   logic m1_rs2;

   assign m1_rs1 = sb_v[1] && (sb_rd[1] == id_rs1) && (id_rs1 != '0);
   assign m1_rs2 = sb_v[1] && (sb_rd[1] == id_rs2) && (id_rs2 != '0);

   assign stall = id_valid && !flush && sb_ld[1] &&
                  ((id_rs1_used && m1_rs1) || (id_rs2_used && m1_rs2));

   // NOTE: every variable gets a default before the loop, so no latch is inferred.
   always_comb begin
      rs1_src = '0;
      rs2_src = '0;
      // Scan oldest to youngest so the youngest match overwrites the others.
      for (int k = DEPTH; k >= 1; k--) begin
         if (id_rs1_used && id_rs1 != '0 && sb_v[k] && sb_rd[k] == id_rs1)
            rs1_src = (k == 2 && sb_ld[k]) ? SEL_LOAD : SEL_W'(k);
         if (id_rs2_used && id_rs2 != '0 && sb_v[k] && sb_rd[k] == id_rs2)
            rs2_src = (k == 2 && sb_ld[k]) ? SEL_LOAD : SEL_W'(k);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every entry
   // shifts from its neighbour's pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge reset2) begin
      if (!reset2) begin
         sb_v  <= '0;
         sb_ld <= '0;
         for (int k = 1; k <= DEPTH; k++)
            sb_rd[k] <= '0;
      end else begin
         for (int k = DEPTH; k >= 2; k--) begin
            sb_v[k]  <= sb_v[k-1];
            sb_ld[k] <= sb_ld[k-1];
            sb_rd[k] <= sb_rd[k-1];
         end
         // A mispredict kills the instruction leaving EX as well as decode.
         if (flush)
            sb_v[2] <= 1'b0;

         if (flush || stall || !id_valid) begin
            sb_v[1]  <= 1'b0;
            sb_ld[1] <= 1'b0;
            sb_rd[1] <= '0;
         end else begin
            sb_v[1]  <= id_reg_write && (id_rd != '0);
            sb_ld[1] <= id_is_load;
            sb_rd[1] <= id_rd;
         end
      end
   end

   always_ff @(posedge clk or negedge reset2) begin
      if (!reset2)
         stall_count <= '0;
      else if (clear_count)
         stall_count <= '0;
      else if (stall && stall_count != CNT_MAX)
         stall_count <= stall_count + 1'b1;
   end

endmodule

// File: tb/tb_fwd_hazard_unit_p.sv
// Directed bench for fwd_hazard_unit_p: forwarding selects, load-use stalls,
// flush, and the stall counter on a 16-bit and a saturating 2-bit instance.
module tb_fwd_hazard_unit_p;

   localparam int REG_AW = 5;
   localparam int DEPTH  = 3;
   localparam int SEL_W  = $clog2(DEPTH + 2);

   logic              clk;
   logic              reset2;
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_rs1_used;
   logic              id_rs2_used;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_write;
   logic              id_is_load;
   logic              flush;
   logic              clear_count;

   logic [SEL_W-1:0]  rs1_src, rs2_src, rs1_src_c, rs2_src_c;
   logic              stall, stall_c;
   logic [15:0]       stall_count;
   logic [1:0]        stall_count_c;

   int n_tests = 0;
   int n_fail  = 0;

   fwd_hazard_unit_p #(.REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .reset2(reset2), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .flush(flush), .clear_count(clear_count),
      .rs1_src(rs1_src), .rs2_src(rs2_src),
      .stall(stall), .stall_count(stall_count)
   );

   fwd_hazard_unit_p #(.REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(2)) dut_c (
      .clk(clk), .reset2(reset2), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .flush(flush), .clear_count(clear_count),
      .rs1_src(rs1_src_c), .rs2_src(rs2_src_c),
      .stall(stall_c), .stall_count(stall_count_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Drive one decode slot, then let the combinational outputs settle.
   task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld, input logic fl);
      id_valid     = v;
      id_rs1       = rs1;
      id_rs1_used  = u1;
      id_rs2       = rs2;
      id_rs2_used  = u2;
      id_rd        = rd;
      id_reg_write = rw;
      id_is_load   = ld;
      flush        = fl;
      #1;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset2      = 1'b0;
      clear_count = 1'b0;
      drive(1, 5, 1, 5, 1, 0, 0, 0, 0);
      #10;
      check("rst_rs1_src", rs1_src, 0);
      check("rst_rs2_src", rs2_src, 0);
      check("rst_stall", stall, 0);
      check("rst_count", stall_count, 0);
      reset2 = 1'b1;
      step();

      // Producer add x5 ages through EX, entry 2, entry 3, then retires.
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
      check("add_stall", stall, 0);
      step();
      drive(1, 5, 1, 5, 1, 0, 0, 0, 0);
      check("fwd_e1_rs1", rs1_src, 1);
      check("fwd_e1_rs2", rs2_src, 1);
      check("fwd_e1_stall", stall, 0);
      step();
      check("fwd_e2_rs1", rs1_src, 2);
      step();
      check("fwd_e3_rs2", rs2_src, 3);
      step();
      check("fwd_gone_rs1", rs1_src, 0);
      check("fwd_gone_rs2", rs2_src, 0);
      step();

      // Load-use on x7: one bubble, then load data select.
      drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
      step();
      drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
      check("lu_stall", stall, 1);
      check("lu_count_before", stall_count, 0);
      step();
      check("lu_stall_after", stall, 0);
      check("lu_rs2_load", rs2_src, DEPTH + 1);
      check("lu_count", stall_count, 1);
      step();

      // Load to x0 is never tracked; an unused operand never forwards.
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
      step();
      drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
      check("x0_rs1", rs1_src, 0);
      check("x0_stall", stall, 0);
      step();
      drive(1, 0, 0, 0, 0, 8, 1, 1, 0);
      step();
      drive(1, 8, 0, 8, 0, 0, 0, 0, 0);
      check("unused_rs1", rs1_src, 0);
      check("unused_rs2", rs2_src, 0);
      check("unused_stall", stall, 0);
      step();

      // x3 in entries 1 and 3, x6 in entry 2.
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
      step();
      drive(1, 0, 0, 0, 0, 6, 1, 0, 0);
      step();
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
      step();
      drive(1, 3, 1, 6, 1, 0, 0, 0, 0);
      check("young_rs1", rs1_src, 1);
      check("young_rs2", rs2_src, 2);
      step();

      // Flushed load creates no entry.
      drive(1, 0, 0, 0, 0, 9, 1, 1, 1);
      check("flush_ld_stall", stall, 0);
      step();
      drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
      check("flush_ld_rs1", rs1_src, 0);
      check("flush_ld_stall2", stall, 0);
      step();

      // Flush while a load-use stall is pending also kills the load in EX.
      drive(1, 0, 0, 0, 0, 10, 1, 1, 0);
      step();
      drive(1, 10, 1, 0, 0, 0, 0, 0, 1);
      check("flush_stall", stall, 0);
      step();
      drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
      check("flush_kill_rs1", rs1_src, 0);
      check("flush_kill_stall", stall, 0);
      check("flush_count", stall_count, 1);
      step();

      // Self-dependent load x7 stalls every other cycle: five more stalls.
      drive(1, 7, 1, 0, 0, 7, 1, 1, 0);
      for (int i = 0; i < 5; i++) begin
         check("sat_nostall", stall, 0);
         step();
         check("sat_stall", stall, 1);
         step();
      end
      check("sat_count16", stall_count, 6);
      check("sat_count2", stall_count_c, 3);

      // clear_count wins over a concurrent stall.
      check("clr_nostall", stall, 0);
      step();
      check("clr_stall", stall, 1);
      clear_count = 1'b1;
      step();
      clear_count = 1'b0;
      check("clr_count16", stall_count, 0);
      check("clr_count2", stall_count_c, 0);

      // Asynchronous reset in the middle of a stall cycle.
      step();
      check("arst_pre_stall", stall, 1);
      #2 reset2 = 1'b0;
      #1;
      check("arst_stall", stall, 0);
      check("arst_rs1", rs1_src, 0);
      check("arst_count", stall_count, 0);
      #2 reset2 = 1'b1;
      drive(1, 7, 1, 7, 1, 0, 0, 0, 0);
      check("arst_empty_rs1", rs1_src, 0);
      check("arst_empty_rs2", rs2_src, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
